// File: rtl/if_id_skid_stage_pkg.sv
// if_id_skid_stage_pkg: shared widths, zero word and boolean constants for the IF->ID skid stage.
package if_id_skid_stage_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;
  localparam int BRIDX_W_DEF = 8;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
endpackage

// File: rtl/if_id_skid_stage_skid_entry_reg.sv
// skid_entry_reg: one valid+payload register; clear zeroes both, load captures, drop only invalidates.
module skid_entry_reg
  import if_id_skid_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid <= FALSE;
      q <= '0;
    end else if (load) begin
      valid <= TRUE;
      q <= d;
    end else if (drop) begin
      valid <= FALSE;
    end
  end
endmodule

// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: IF->ID valid/ready boundary with head+skid entries and a registered in_ready.
// Optional IF_ID_PERF_EN adds saturating stall/flush counters.
module if_id_skid_stage
  import if_id_skid_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int BRIDX_W = BRIDX_W_DEF
`ifdef IF_ID_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [INST_W-1:0]  in_inst,
  input  logic [BRIDX_W-1:0] in_br_index,
  input  logic               in_prd_jmp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INST_W-1:0]  out_inst,
  output logic [BRIDX_W-1:0] out_br_index,
  output logic               out_prd_jmp
`ifdef IF_ID_PERF_EN
  , output logic [CNT_W-1:0] perf_stall
  , output logic [CNT_W-1:0] perf_flush
`endif
);
  localparam int PW = ADDR_W + INST_W + BRIDX_W + 1;
  logic head_valid, skid_valid, accept, pop, advance;
  logic head_load, head_drop, skid_load, skid_drop;
  logic [PW-1:0] in_pay, head_q, skid_q, head_d;
  assign in_pay = {in_pc, in_inst, in_br_index, in_prd_jmp};
  assign {out_pc, out_inst, out_br_index, out_prd_jmp} = head_q;
  assign out_valid = head_valid;
  // skid_valid is itself a flop, so in_ready has no combinational path from out_ready
  assign in_ready = ~skid_valid;
  assign accept = in_valid & in_ready;
  assign pop = head_valid & out_ready;
  assign advance = ~head_valid | pop;
  assign head_load = advance & (skid_valid | accept);
  assign head_drop = advance & ~skid_valid & ~accept;
  assign head_d = skid_valid ? skid_q : in_pay;
  assign skid_load = accept & (~advance | skid_valid);
  assign skid_drop = advance & skid_valid;
  skid_entry_reg #(.W(PW)) u_head (
    .clk(clk), .rst(rst), .clr(flush), .load(head_load), .drop(head_drop),
    .d(head_d), .valid(head_valid), .q(head_q)
  );
  skid_entry_reg #(.W(PW)) u_skid (
    .clk(clk), .rst(rst), .clr(flush), .load(skid_load), .drop(skid_drop),
    .d(in_pay), .valid(skid_valid), .q(skid_q)
  );
`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (head_valid && !out_ready && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
      if (flush && (head_valid || skid_valid) && perf_flush != '1) perf_flush <= perf_flush + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb_if_id_skid_stage: directed checks of streaming, backpressure, flush and reset for the skid stage.
module tb_if_id_skid_stage;
  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, in_prd_jmp, out_valid, out_ready, out_prd_jmp;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [7:0] in_br_index, out_br_index;
  int checks = 0;
  int failures = 0;
`ifdef IF_ID_PERF_EN
  logic [31:0] perf_stall, perf_flush;
`endif
  if_id_skid_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_br_index(in_br_index), .in_prd_jmp(in_prd_jmp),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_br_index(out_br_index), .out_prd_jmp(out_prd_jmp)
`ifdef IF_ID_PERF_EN
    , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    in_valid = v;
    in_pc = pc;
    in_inst = {16'hbeef, pc[15:0]};
    in_br_index = pc[9:2];
    in_prd_jmp = pc[2];
    out_ready = rdy;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_pc"}, 64'(out_pc), 64'(pc));
    chk({tag, "_inst"}, 64'(out_inst), 64'({16'hbeef, pc[15:0]}));
    chk({tag, "_bridx"}, 64'(out_br_index), 64'(pc[9:2]));
    chk({tag, "_prd"}, 64'(out_prd_jmp), 64'(pc[2]));
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_pc"}, 64'(out_pc), 64'd0);
    chk({tag, "_inst"}, 64'(out_inst), 64'd0);
    chk({tag, "_bridx"}, 64'(out_br_index), 64'd0);
    chk({tag, "_prd"}, 64'(out_prd_jmp), 64'd0);
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick;
    tick;
    rst = 1'b0;
    chk_cleared("reset");
    // stream: each PC appears one cycle after it is offered, no bubbles
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b1);
      tick;
      chk_head($sformatf("stream%0d", i), 32'h100 + 32'(4 * i));
      chk($sformatf("stream%0d_ready", i), 64'(in_ready), 64'd1);
    end
    drive(1'b0, 32'h0, 1'b1);
    tick;
    chk("stream_drain", 64'(out_valid), 64'd0);
    // backpressure at 0x104
    drive(1'b1, 32'h100, 1'b1);
    tick;
    drive(1'b1, 32'h104, 1'b1);
    tick;
    chk_head("bp_head", 32'h104);
    drive(1'b1, 32'h108, 1'b0);
    tick;
    chk_head("bp_hold", 32'h104);
    chk("bp_ready_lo", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h10C, 1'b0);
    tick;
    chk_head("bp_stable", 32'h104);
    chk("bp_ready_still_lo", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h10C, 1'b1);
    tick;
    chk_head("bp_out1", 32'h108);
    chk("bp_ready_hi", 64'(in_ready), 64'd1);
    tick;
    chk_head("bp_out2", 32'h10C);
    drive(1'b0, 32'h0, 1'b1);
    tick;
    chk("bp_empty", 64'(out_valid), 64'd0);
    // pop with skid full: skid moves to head, new input waits for in_ready
    drive(1'b1, 32'h300, 1'b0);
    tick;
    drive(1'b1, 32'h304, 1'b0);
    tick;
    chk_head("full_head", 32'h300);
    chk("full_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h308, 1'b1);
    tick;
    chk_head("pa_1", 32'h304);
    tick;
    chk_head("pa_2", 32'h308);
    drive(1'b1, 32'h30C, 1'b1);
    tick;
    chk_head("pa_3", 32'h30C);
    drive(1'b0, 32'h0, 1'b1);
    tick;
    chk("pa_empty", 64'(out_valid), 64'd0);
    // flush while full, with an offered input that must be discarded
    drive(1'b1, 32'h400, 1'b0);
    tick;
    drive(1'b1, 32'h404, 1'b0);
    tick;
    flush = 1'b1;
    drive(1'b1, 32'h408, 1'b1);
    tick;
    flush = 1'b0;
    chk_cleared("flush");
    drive(1'b1, 32'h200, 1'b0);
    tick;
    chk_head("post_flush", 32'h200);
    drive(1'b0, 32'h0, 1'b1);
    tick;
    chk("post_flush_empty", 64'(out_valid), 64'd0);
    // reset mid-stream with two held entries
    drive(1'b1, 32'h500, 1'b0);
    tick;
    drive(1'b1, 32'h504, 1'b0);
    tick;
    chk("rst_pre_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    chk_cleared("rst_mid");
`ifdef IF_ID_PERF_EN
    chk("rst_perf_stall", 64'(perf_stall), 64'd0);
    chk("rst_perf_flush", 64'(perf_flush), 64'd0);
    drive(1'b1, 32'h600, 1'b0);
    tick;
    drive(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) tick;
    chk("perf_stall5", 64'(perf_stall), 64'd5);
    flush = 1'b1;
    out_ready = 1'b1;
    tick;
    chk("perf_flush1", 64'(perf_flush), 64'd1);
    chk("perf_stall_after_flush", 64'(perf_stall), 64'd5);
    tick;
    flush = 1'b0;
    chk("perf_flush_empty", 64'(perf_flush), 64'd1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
